// File: rtl/eif_tdm_if.sv
// Handshake bundle between the TDM scheduler (master) and the shared EIF update datapath (slave).
interface eif_tdm_if #(
  parameter int STATE_W = 8,
  parameter int CUR_W   = 8
) ();
  logic               dp_req;
  logic [STATE_W-1:0] dp_state;
  logic [CUR_W-1:0]   dp_current;
  logic               dp_done;
  logic [STATE_W-1:0] dp_next;
  logic               dp_spike;

  modport master (output dp_req, dp_state, dp_current, input dp_done, dp_next, dp_spike);
  modport slave  (input dp_req, dp_state, dp_current, output dp_done, dp_next, dp_spike);
endinterface

// File: rtl/eif_tdm_scheduler.sv
// Round-robin scheduler sharing one EIF update datapath across N_NEURONS stored neuron states.
// Optional refractory skipping is compiled in with `define EIF_REFRACTORY_EN.

// Per-neuron storage: membrane state, last spike flag and (optionally) refractory counter.
module eif_tdm_cell #(
  parameter int STATE_W = 8
`ifdef EIF_REFRACTORY_EN
  , parameter int REFRAC_SWEEPS = 2
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic               skip,
  input  logic [STATE_W-1:0] wr_state,
  input  logic               wr_spike,
  output logic [STATE_W-1:0] state,
  output logic               spike,
  output logic               busy
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= '0;
      spike <= 1'b0;
    end else if (wr_en) begin
      state <= skip ? '0 : wr_state;
      spike <= !skip && wr_spike;
    end
  end

`ifdef EIF_REFRACTORY_EN
  localparam int RC_W = $clog2(REFRAC_SWEEPS + 1);
  logic [RC_W-1:0] cnt;

  // A skipped writeback consumes one refractory sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (wr_en) begin
      if (skip)
        cnt <= cnt - 1'b1;
      else if (wr_spike)
        cnt <= RC_W'(REFRAC_SWEEPS);
    end
  end
  assign busy = |cnt;
`else
  assign busy = 1'b0;
`endif
endmodule

module eif_tdm_scheduler #(
  parameter int N_NEURONS     = 4,
  parameter int STATE_W       = 8,
  parameter int CUR_W         = 8,
  parameter int TIMEOUT       = 15,
  parameter int REFRAC_SWEEPS = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         run,
  input  logic [N_NEURONS*CUR_W-1:0]   cur_in,
  eif_tdm_if.master                    dp,
  output logic [$clog2(N_NEURONS)-1:0] slot,
  output logic [N_NEURONS-1:0]         spike_vec,
  output logic                         frame_done,
  input  logic [$clog2(N_NEURONS)-1:0] rd_sel,
  output logic [STATE_W-1:0]           rd_state,
  output logic                         err
);
  localparam int SW = $clog2(N_NEURONS);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_WB    = 2'd3;

  logic [1:0]                            fsm;
  logic [TW-1:0]                         timer;
  logic [STATE_W-1:0]                    res_state;
  logic                                  res_spike;
  logic                                  wb_write;
  logic                                  wb_skip;
  logic [N_NEURONS-1:0][CUR_W-1:0]       cur_arr;
  logic [N_NEURONS-1:0][STATE_W-1:0]     states;
  logic [N_NEURONS-1:0]                  busy;
  logic [N_NEURONS-1:0]                  wr_en;

  assign cur_arr     = cur_in;
  assign dp.dp_state = states[slot];
  assign rd_state    = states[rd_sel];

  genvar i;
  generate
    for (i = 0; i < N_NEURONS; i++) begin : g_lane
      assign wr_en[i] = (fsm == S_WB) && (slot == SW'(i)) && (wb_write || wb_skip);

      eif_tdm_cell #(
        .STATE_W(STATE_W)
`ifdef EIF_REFRACTORY_EN
        , .REFRAC_SWEEPS(REFRAC_SWEEPS)
`endif
      ) u_cell (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en[i]),
        .skip     (wb_skip),
        .wr_state (res_state),
        .wr_spike (res_spike),
        .state    (states[i]),
        .spike    (spike_vec[i]),
        .busy     (busy[i])
      );
    end
  endgenerate

  // dp_req is registered: it rises on leaving ISSUE and falls on leaving WAIT,
  // so operands are already stable for the whole time it is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm           <= S_IDLE;
      slot          <= '0;
      timer         <= '0;
      dp.dp_req     <= 1'b0;
      dp.dp_current <= '0;
      res_state     <= '0;
      res_spike     <= 1'b0;
      wb_write      <= 1'b0;
      wb_skip       <= 1'b0;
      err           <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (fsm)
        S_IDLE: begin
          if (run) fsm <= S_ISSUE;
        end
        S_ISSUE: begin
          dp.dp_current <= cur_arr[slot];
          timer         <= '0;
          wb_write      <= 1'b0;
          if (busy[slot]) begin
            wb_skip <= 1'b1;
            fsm     <= S_WB;
          end else begin
            wb_skip   <= 1'b0;
            dp.dp_req <= 1'b1;
            fsm       <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A result arriving on the final allowed cycle still wins over the timeout.
          if (dp.dp_done) begin
            res_state <= dp.dp_next;
            res_spike <= dp.dp_spike;
            wb_write  <= 1'b1;
            dp.dp_req <= 1'b0;
            fsm       <= S_WB;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            err       <= 1'b1;
            wb_write  <= 1'b0;
            dp.dp_req <= 1'b0;
            fsm       <= S_WB;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          wb_write <= 1'b0;
          wb_skip  <= 1'b0;
          if (slot == SW'(N_NEURONS - 1)) begin
            slot       <= '0;
            frame_done <= 1'b1;
          end else begin
            slot <= slot + 1'b1;
          end
          fsm <= run ? S_ISSUE : S_IDLE;
        end
      endcase
    end
  end
endmodule
